// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg
// Shared constants for the CPU retire/trace monitor.
// Contents:
//   - RV64 major opcode constants used to classify retiring instructions
//   - class index constants (NUM_CLASS = 6)
//   - monitor state encoding (RUN / DRAIN / HALTED)
//   - classify(): opcode -> class index
package cpu_trace_pkg;

  localparam logic [6:0] OP_R_ALU  = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int NUM_CLASS = 6;

  localparam logic [2:0] CLS_R_ALU  = 3'd0;
  localparam logic [2:0] CLS_I_ALU  = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_OTHER  = 3'd5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Map a major opcode onto its counter index; anything unknown is "other".
  function automatic logic [2:0] classify(input logic [6:0] opcode);
    logic [2:0] cls;
    case (opcode)
      OP_R_ALU:  cls = CLS_R_ALU;
      OP_I_ALU:  cls = CLS_I_ALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cpu_trace_monitor_if.sv
// cpu_trace_monitor_if
// Bundles the retire bus (CPU -> monitor) and the trace stream
// (monitor -> consumer, ready/valid).
// Modports:
//   master : CPU/consumer side (drives retire_*, trace_ready)
//   slave  : monitor side (samples retire_*, drives trace_*)
// Optional macro TRACE_MEM_EN adds the memory-access fields.
interface cpu_trace_monitor_if #(
  parameter int XLEN = 64
) ();
  logic            retire_valid;
  logic [XLEN-1:0] pc;
  logic [31:0]     instruction;
  logic            reg_write;
  logic [4:0]      rd;
  logic [XLEN-1:0] reg_write_data;

  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [31:0]     trace_instr;
  logic [4:0]      trace_rd;
  logic [XLEN-1:0] trace_wdata;

`ifdef TRACE_MEM_EN
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] mem_data;
  logic            trace_mem_we;
  logic            trace_mem_re;
  logic [XLEN-1:0] trace_mem_addr;
  logic [XLEN-1:0] trace_mem_data;
`endif

  modport master (
    output retire_valid, pc, instruction, reg_write, rd, reg_write_data, trace_ready,
    input  trace_valid, trace_pc, trace_instr, trace_rd, trace_wdata
`ifdef TRACE_MEM_EN
    , output mem_read, mem_write, alu_result, mem_data
    , input  trace_mem_we, trace_mem_re, trace_mem_addr, trace_mem_data
`endif
  );

  modport slave (
    input  retire_valid, pc, instruction, reg_write, rd, reg_write_data, trace_ready,
    output trace_valid, trace_pc, trace_instr, trace_rd, trace_wdata
`ifdef TRACE_MEM_EN
    , input  mem_read, mem_write, alu_result, mem_data
    , output trace_mem_we, trace_mem_re, trace_mem_addr, trace_mem_data
`endif
  );

endinterface

// File: rtl/trace_fifo.sv
// trace_fifo
// Synchronous FIFO holding packed trace entries.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata : write request / entry; accepted when not full, or when
//                 full and a pop happens in the same cycle
//   pop         : read request; ignored when empty
//   rdata       : head entry, forced to zero while empty
//   full, empty : occupancy flags
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign empty  = (count_r == {(AW+1){1'b0}});
  assign full   = (count_r == CNT_FULL);
  assign pop_s  = pop && !empty;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign push_s = push && (!full || pop_s);
  assign rdata  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor
// Retire monitor: captures retiring instructions into a trace FIFO drained
// by ready/valid, keeps cycle/retire/per-class/drop counters, and on the
// halt word drains the FIFO and then reports halted.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : retire_* inputs, trace_* ready/valid outputs
//   cycle_count  : cycles since reset (wraps)
//   instret      : retirements seen in RUN (wraps)
//   class_count  : 6 packed counters [R-ALU,I-ALU,load,store,branch,other]
//   drop_count   : retirements lost to a full FIFO (saturating)
//   halted       : halt seen and FIFO fully drained (sticky until reset)
// Optional macro TRACE_MEM_EN: store memory access fields per entry.
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter int          DEPTH      = 16,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  cpu_trace_monitor_if.slave         bus,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [CNT_W-1:0]           instret,
  output logic [NUM_CLASS*CNT_W-1:0] class_count,
  output logic [CNT_W-1:0]           drop_count,
  output logic                       halted
);
`ifdef TRACE_MEM_EN
  localparam int ENTRY_W = 4*XLEN + 39;
`else
  localparam int ENTRY_W = 2*XLEN + 37;
`endif
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_t             state_r;
  logic [CNT_W-1:0]   class_cnt_r [NUM_CLASS];
  logic [ENTRY_W-1:0] entry_s;
  logic [ENTRY_W-1:0] head_s;
  logic [4:0]         rd_f_s;
  logic [XLEN-1:0]    wdata_f_s;
  logic [2:0]         cls_s;
  logic               capture_s;
  logic               is_halt_s;
  logic               pop_s;
  logic               drop_s;
  logic               full_s;
  logic               empty_s;

  assign is_halt_s = (bus.instruction == HALT_INSTR);
  assign capture_s = (state_r == RUN) && bus.retire_valid;
  assign pop_s     = bus.trace_valid && bus.trace_ready;
  assign drop_s    = capture_s && full_s && !pop_s;

  // Register write fields are only meaningful for a real write to x1..x31.
  always_comb begin
    rd_f_s    = 5'd0;
    wdata_f_s = {XLEN{1'b0}};
    if (bus.reg_write && (bus.rd != 5'd0)) begin
      rd_f_s    = bus.rd;
      wdata_f_s = bus.reg_write_data;
    end else begin
      rd_f_s    = 5'd0;
      wdata_f_s = {XLEN{1'b0}};
    end
  end

  // The halt word always counts as "other" even if its opcode decodes.
  always_comb begin
    cls_s = CLS_OTHER;
    if (is_halt_s) begin
      cls_s = CLS_OTHER;
    end else begin
      cls_s = classify(bus.instruction[6:0]);
    end
  end

`ifdef TRACE_MEM_EN
  logic            mem_acc_s;
  logic [XLEN-1:0] mem_addr_f_s;
  logic [XLEN-1:0] mem_data_f_s;

  assign mem_acc_s = bus.mem_read || bus.mem_write;

  // Address/data are zeroed unless this instruction touched memory.
  always_comb begin
    mem_addr_f_s = {XLEN{1'b0}};
    mem_data_f_s = {XLEN{1'b0}};
    if (mem_acc_s) begin
      mem_addr_f_s = bus.alu_result;
      mem_data_f_s = bus.mem_data;
    end else begin
      mem_addr_f_s = {XLEN{1'b0}};
      mem_data_f_s = {XLEN{1'b0}};
    end
  end

  assign entry_s = {bus.pc, bus.instruction, rd_f_s, wdata_f_s,
                    bus.mem_write, bus.mem_read, mem_addr_f_s, mem_data_f_s};
  assign {bus.trace_pc, bus.trace_instr, bus.trace_rd, bus.trace_wdata,
          bus.trace_mem_we, bus.trace_mem_re, bus.trace_mem_addr, bus.trace_mem_data} = head_s;
`else
  assign entry_s = {bus.pc, bus.instruction, rd_f_s, wdata_f_s};
  assign {bus.trace_pc, bus.trace_instr, bus.trace_rd, bus.trace_wdata} = head_s;
`endif

  assign bus.trace_valid = !empty_s;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture_s),
    .pop   (pop_s),
    .wdata (entry_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // RUN -> DRAIN on halt; DRAIN -> HALTED once the FIFO has emptied.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      halted  <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (capture_s && is_halt_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty_s) begin
            state_r <= HALTED;
            halted  <= 1'b1;
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state_r <= RUN;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  // Cycle, retire, class and drop counters; a dropped entry still retired.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= {CNT_W{1'b0}};
      instret     <= {CNT_W{1'b0}};
      drop_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < NUM_CLASS; i++) begin
        class_cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      cycle_count <= cycle_count + CNT_ONE;
      if (capture_s) begin
        instret <= instret + CNT_ONE;
      end
      for (int i = 0; i < NUM_CLASS; i++) begin
        if (capture_s && (cls_s == 3'(i))) begin
          class_cnt_r[i] <= class_cnt_r[i] + CNT_ONE;
        end
      end
      if (drop_s && (drop_count != {CNT_W{1'b1}})) begin
        drop_count <= drop_count + CNT_ONE;
      end
    end
  end

  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_class_out
    assign class_count[g*CNT_W +: CNT_W] = class_cnt_r[g];
  end

endmodule
